led_stream_decoder: RTL
=======================

LED_STREAM_DECODER -- requirements
Module: led_stream_decoder

Interface
REQ-001 SHALL have parameter T_BIT_THRESH, default 30, meaning the high-pulse length in clk cycles at or above which a bit decodes as 1.
REQ-002 SHALL have parameter T_MIN_HIGH, default 8, meaning the shortest legal high pulse in cycles.
REQ-003 SHALL have parameter T_MAX_HIGH, default 60, meaning the longest legal high pulse in cycles.
REQ-004 SHALL have parameter T_RESET, default 2500, meaning the low-gap length in cycles that ends a frame (50 us at 50 MHz).
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 din  input  1  asynchronous serial LED stream (WS2812-style, GRB, MSB first).
REQ-008 pixel_valid  output  1  one-cycle pulse; pixel_data and pixel_index are valid.
REQ-009 pixel_data  output  24  decoded pixel, first received bit in bit 23.
REQ-010 pixel_index  output  16  zero-based position of the pixel in the current frame.
REQ-011 frame_done  output  1  one-cycle pulse when a reset gap is detected after at least one bit.
REQ-012 bit_error  output  1  one-cycle pulse on an illegal pulse or a truncated pixel.
REQ-013 synced  output  1  high once a full reset gap has been seen since rst.

Function
REQ-014 SHALL pass din through a 2-flop synchronizer (din_s), plus one history flop for edge detection; all timing uses din_s.
REQ-015 SHALL implement states SYNC, IDLE, HIGH, LOW.
REQ-016 SYNC: count consecutive low cycles; on reaching T_RESET, go to IDLE and set synced=1; any high cycle clears the count; no pixels, errors or frame_done are emitted in SYNC.
REQ-017 IDLE/LOW rising edge of din_s: go to HIGH, with high_cnt=1 in that cycle, incrementing each further high cycle and saturating at T_MAX_HIGH+1.
REQ-018 HIGH falling edge: if T_MIN_HIGH <= high_cnt <= T_MAX_HIGH, shift bit (high_cnt >= T_BIT_THRESH) into the shift register and increment bit_cnt; otherwise pulse bit_error, clear bit_cnt, and discard the partial pixel. In either case, go to LOW with low_cnt=1.
REQ-019 HIGH, while high_cnt exceeds T_MAX_HIGH: pulse bit_error once, clear bit_cnt, and go to SYNC.
REQ-020 When bit_cnt reaches 24, SHALL pulse pixel_valid in the cycle after the falling edge that accepted the 24th bit, drive pixel_data and pixel_index, and clear bit_cnt.
REQ-021 pixel_data and pixel_index SHALL hold their values until the next pixel_valid.
REQ-022 pixel_index SHALL increment after each pixel_valid, saturate at 16'hFFFF, and clear to 0 on frame_done.
REQ-023 LOW: count low cycles, saturating at T_RESET; on reaching T_RESET, pulse frame_done if any bit was accepted since the last frame_done, and go to IDLE.
REQ-024 LOW reaching T_RESET with bit_cnt != 0: also pulse bit_error in the same cycle and discard the partial pixel.
REQ-025 A last-bit pixel_valid and a frame_done SHALL never coincide; the reset gap needs T_RESET cycles, which is always more than 1.
REQ-026 IDLE SHALL count low cycles like LOW but never emit frame_done.
REQ-027 All counters SHALL be wide enough for T_RESET, and comparisons SHALL be unsigned.

Reset
REQ-028 rst SHALL force: state=SYNC, synchronizer flops=0, all counters=0, shift register=0, pixel_data=0, pixel_index=0, pixel_valid=0, frame_done=0, bit_error=0, synced=0.
REQ-029 rst asserted mid-pixel SHALL discard all progress; no pulse is emitted in the cycle after rst deasserts.
REQ-030 rst SHALL take priority over every other event in the same cycle.

Verification
REQ-031 din low for 2500 cycles, then 24 bits of pattern 0x00FF00 (0 = 20 high/40 low, 1 = 40 high/20 low) -> synced=1, one pixel_valid with pixel_data=0x00FF00 and pixel_index=0.
REQ-032 Three pixels 0x123456, 0xABCDEF, 0x000001 followed by a 2500-cycle low -> pixel_index 0,1,2 in order, then one frame_done; pixel_index reads 0 afterwards.
REQ-033 12 valid bits, then a 2500-cycle low -> bit_error and frame_done in the same cycle, no pixel_valid; the next pixel decodes with pixel_index=0.
REQ-034 A 4-cycle high pulse mid-pixel -> bit_error, bit_cnt cleared; the following 24 good bits decode to a correct pixel.
REQ-035 A 100-cycle high pulse -> a single bit_error and return to SYNC; no pixel decodes until a new 2500-cycle gap has passed.
REQ-036 Boundary pulses: high_cnt=29 -> bit 0; 30 -> bit 1; 8 and 60 accepted; 7 and 61 -> bit_error.
REQ-037 rst asserted while 20 bits into a pixel -> all outputs 0 and synced=0; bits sent before a full gap are ignored.

Source files
------------

// File: rtl/led_stream_decoder.sv
// rtl/led_stream_decoder.sv - WS2812-style serial LED stream decoder producing 24-bit pixels
module led_stream_decoder #(
    parameter int unsigned T_BIT_THRESH = 30,
    parameter int unsigned T_MIN_HIGH   = 8,
    parameter int unsigned T_MAX_HIGH   = 60,
    parameter int unsigned T_RESET      = 2500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic        pixel_valid,
    output logic [23:0] pixel_data,
    output logic [15:0] pixel_index,
    output logic        frame_done,
    output logic        bit_error,
    output logic        synced
);
    localparam int unsigned CNT_MAX = (T_RESET > T_MAX_HIGH + 1) ? T_RESET : T_MAX_HIGH + 1;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] C_ONE      = CW'(1);
    localparam logic [CW-1:0] C_THRESH   = CW'(T_BIT_THRESH);
    localparam logic [CW-1:0] C_MIN      = CW'(T_MIN_HIGH);
    localparam logic [CW-1:0] C_MAX      = CW'(T_MAX_HIGH);
    localparam logic [CW-1:0] C_RESET    = CW'(T_RESET);
    localparam logic [CW-1:0] C_RESET_M1 = CW'(T_RESET - 1);

    typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

    state_t        state_q, state_d;
    logic          din_meta_q, din_s_q, din_prev_q;
    logic [CW-1:0] high_cnt_q, high_cnt_d;
    logic [CW-1:0] low_cnt_q, low_cnt_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [23:0]   shift_q, shift_d;
    logic          any_bit_q, any_bit_d;
    logic [15:0]   idx_cnt_q, idx_cnt_d;
    logic          pixel_valid_q, pixel_valid_d;
    logic [23:0]   pixel_data_q, pixel_data_d;
    logic [15:0]   pixel_index_q, pixel_index_d;
    logic          frame_done_q, frame_done_d;
    logic          bit_error_q, bit_error_d;
    logic          synced_q, synced_d;
    logic          rise, fall, bit_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_SYNC;
            din_meta_q    <= 1'b0;
            din_s_q       <= 1'b0;
            din_prev_q    <= 1'b0;
            high_cnt_q    <= '0;
            low_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            any_bit_q     <= 1'b0;
            idx_cnt_q     <= '0;
            pixel_valid_q <= 1'b0;
            pixel_data_q  <= '0;
            pixel_index_q <= '0;
            frame_done_q  <= 1'b0;
            bit_error_q   <= 1'b0;
            synced_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            din_meta_q    <= din;
            din_s_q       <= din_meta_q;
            din_prev_q    <= din_s_q;
            high_cnt_q    <= high_cnt_d;
            low_cnt_q     <= low_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            any_bit_q     <= any_bit_d;
            idx_cnt_q     <= idx_cnt_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_data_q  <= pixel_data_d;
            pixel_index_q <= pixel_index_d;
            frame_done_q  <= frame_done_d;
            bit_error_q   <= bit_error_d;
            synced_q      <= synced_d;
        end
    end

    assign rise    = din_s_q & ~din_prev_q;
    assign fall    = ~din_s_q & din_prev_q;
    assign bit_val = (high_cnt_q >= C_THRESH);

    always_comb begin
        state_d       = state_q;
        high_cnt_d    = high_cnt_q;
        low_cnt_d     = low_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        any_bit_d     = any_bit_q;
        idx_cnt_d     = idx_cnt_q;
        pixel_valid_d = 1'b0;
        pixel_data_d  = pixel_data_q;
        pixel_index_d = pixel_index_q;
        frame_done_d  = 1'b0;
        bit_error_d   = 1'b0;
        synced_d      = synced_q;
        case (state_q)
            S_SYNC: begin
                if (din_s_q) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q >= C_RESET_M1) begin
                    low_cnt_d = C_RESET;
                    state_d   = S_IDLE;
                    synced_d  = 1'b1;
                end else begin
                    low_cnt_d = low_cnt_q + C_ONE;
                end
            end
            S_IDLE, S_LOW: begin
                if (rise) begin
                    state_d    = S_HIGH;
                    high_cnt_d = C_ONE;
                end else if (low_cnt_q < C_RESET) begin
                    low_cnt_d = low_cnt_q + C_ONE;
                    // Only a gap that follows pulses ends a frame; IDLE just keeps counting.
                    if (low_cnt_q == C_RESET_M1 && state_q == S_LOW) begin
                        state_d      = S_IDLE;
                        frame_done_d = any_bit_q;
                        bit_error_d  = (bit_cnt_q != 5'd0);
                        bit_cnt_d    = '0;
                        shift_d      = '0;
                        if (any_bit_q) begin
                            any_bit_d     = 1'b0;
                            idx_cnt_d     = '0;
                            pixel_index_d = '0;
                        end
                    end
                end
            end
            S_HIGH: begin
                if (fall) begin
                    state_d   = S_LOW;
                    low_cnt_d = C_ONE;
                    if (high_cnt_q >= C_MIN && high_cnt_q <= C_MAX) begin
                        shift_d   = {shift_q[22:0], bit_val};
                        any_bit_d = 1'b1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d     = '0;
                            pixel_valid_d = 1'b1;
                            pixel_data_d  = {shift_q[22:0], bit_val};
                            pixel_index_d = idx_cnt_q;
                            if (idx_cnt_q != 16'hFFFF) idx_cnt_d = idx_cnt_q + 16'd1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        bit_error_d = 1'b1;
                        bit_cnt_d   = '0;
                        shift_d     = '0;
                    end
                end else if (high_cnt_q > C_MAX) begin
                    // Stuck-high line: lose framing and wait for a fresh reset gap.
                    state_d     = S_SYNC;
                    low_cnt_d   = '0;
                    bit_error_d = 1'b1;
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                end else begin
                    high_cnt_d = high_cnt_q + C_ONE;
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_comb begin
        pixel_valid = pixel_valid_q;
        pixel_data  = pixel_data_q;
        pixel_index = pixel_index_q;
        frame_done  = frame_done_q;
        bit_error   = bit_error_q;
        synced      = synced_q;
    end
endmodule
